// File: rtl/mem_bus_ctrl_pkg.sv
// rtl/mem_bus_ctrl_pkg.sv - shared widths, FSM encoding and helpers for the memory-port sequencer
//
// Contents:
//   MEM_ADDR_WIDTH / MEM_DATA_WIDTH : default bus widths shared by the datapath
//   state_t                         : sequencer states (IDLE = 0, ACCESS = 1, DONE = 2)
//   is_word_aligned()               : word-alignment test on the low address bits

package mem_bus_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Only word accesses exist on this port, so any set bit in [1:0] is an alignment fault.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - request, status and memory-port signal bundle of the sequencer
//
// Signals:
//   req_valid/req_we/req_ir_load/req_addr/req_wdata : access request from the control FSM
//   busy/done/err_align/err_timeout                 : status back to the control and cause logic
//   ir_out/mdr_out                                  : instruction and memory data registers
//   mem_req/mem_we/mem_addr/mem_wdata               : request side of the memory handshake
//   mem_ack/mem_rdata                               : response side of the memory handshake
// Modports:
//   slave  : the sequencer (mem_bus_ctrl)
//   master : the environment (control FSM plus memory)

interface mem_bus_ctrl_if
    import mem_bus_ctrl_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_BUS_WIDTH    = MEM_DATA_WIDTH
);

    logic                         req_valid;
    logic                         req_we;
    logic                         req_ir_load;
    logic [ADDRESS_BUS_WIDTH-1:0] req_addr;
    logic [DATA_BUS_WIDTH-1:0]    req_wdata;

    logic                         busy;
    logic                         done;
    logic                         err_align;
    logic                         err_timeout;
    logic [DATA_BUS_WIDTH-1:0]    ir_out;
    logic [DATA_BUS_WIDTH-1:0]    mdr_out;

    logic                         mem_req;
    logic                         mem_we;
    logic [ADDRESS_BUS_WIDTH-1:0] mem_addr;
    logic [DATA_BUS_WIDTH-1:0]    mem_wdata;
    logic                         mem_ack;
    logic [DATA_BUS_WIDTH-1:0]    mem_rdata;

    modport slave (
        input  req_valid, req_we, req_ir_load, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output busy, done, err_align, err_timeout, ir_out, mdr_out,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_ir_load, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  busy, done, err_align, err_timeout, ir_out, mdr_out,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - ack wait counter with terminal count at TIMEOUT_CYCLES-1
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart counting from zero (has priority over enable)
//   enable       : advance by one; saturates at the terminal value
//   terminal     : high while the count equals TIMEOUT_CYCLES-1

module mem_wait_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - multicycle memory-port sequencer with IR/MDR capture and fault flags
//
// Ports:
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset; clears state and every output
//   bus     : mem_bus_ctrl_if.slave - request, status, IR/MDR and memory handshake
// Parameters:
//   ADDRESS_BUS_WIDTH, DATA_BUS_WIDTH : must match the connected interface instance
//   TIMEOUT_CYCLES                    : cycles mem_req is held without ack (>= 2)

module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_BUS_WIDTH    = MEM_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input logic           clk,
    input logic           reset_n,
    mem_bus_ctrl_if.slave bus
);

    state_t state;
    state_t state_nx;

    logic                         busy_q;
    logic                         done_q;
    logic                         mem_req_q;
    logic                         mem_we_q;
    logic                         ir_load_q;
    logic                         err_align_q;
    logic                         err_timeout_q;
    logic [ADDRESS_BUS_WIDTH-1:0] mem_addr_q;
    logic [DATA_BUS_WIDTH-1:0]    mem_wdata_q;
    logic [DATA_BUS_WIDTH-1:0]    ir_q;
    logic [DATA_BUS_WIDTH-1:0]    mdr_q;

    logic aligned;
    logic wait_terminal;

    // Decoded actions, produced by the output process and consumed by the register process.
    logic busy_d;
    logic done_d;
    logic mem_req_d;
    logic accept;
    logic reject;
    logic read_load;
    logic timeout_hit;
    logic wait_enable;

    assign aligned = is_word_aligned(bus.req_addr[1:0]);

    mem_wait_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  (wait_enable),
        .terminal(wait_terminal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_nx = aligned ? ST_ACCESS : ST_DONE;
                end
            end
            ST_ACCESS: begin
                // An ack arriving on the terminal cycle still completes normally.
                if (bus.mem_ack || wait_terminal) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so that, once registered,
    // they line up with the state they describe.
    always_comb begin
        busy_d      = (state_nx != ST_IDLE);
        done_d      = (state_nx == ST_DONE);
        mem_req_d   = (state_nx == ST_ACCESS);
        accept      = (state == ST_IDLE) && bus.req_valid && aligned;
        reject      = (state == ST_IDLE) && bus.req_valid && !aligned;
        read_load   = (state == ST_ACCESS) && bus.mem_ack && !mem_we_q;
        timeout_hit = (state == ST_ACCESS) && !bus.mem_ack && wait_terminal;
        wait_enable = (state == ST_ACCESS) && !bus.mem_ack;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            ir_load_q     <= 1'b0;
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            ir_q          <= '0;
            mdr_q         <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            mem_req_q <= mem_req_d;

            if (accept) begin
                mem_addr_q    <= bus.req_addr;
                mem_wdata_q   <= bus.req_wdata;
                mem_we_q      <= bus.req_we;
                ir_load_q     <= bus.req_ir_load;
                err_align_q   <= 1'b0;
                err_timeout_q <= 1'b0;
            end

            // A misaligned request never reaches memory; address registers keep the last access.
            if (reject) begin
                err_align_q   <= 1'b1;
                err_timeout_q <= 1'b0;
            end

            if (timeout_hit) begin
                err_timeout_q <= 1'b1;
            end

            if (read_load) begin
                if (ir_load_q) begin
                    ir_q <= bus.mem_rdata;
                end else begin
                    mdr_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_align   = err_align_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.ir_out      = ir_q;
    assign bus.mdr_out     = mdr_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - self-checking bench for mem_bus_ctrl against a transaction-level model

module tb_mem_bus_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.ADDRESS_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW)) bus ();

    mem_bus_ctrl #(
        .ADDRESS_BUS_WIDTH(AW),
        .DATA_BUS_WIDTH   (DW),
        .TIMEOUT_CYCLES   (T)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Architectural state the model expects to be visible on the outputs.
    logic [DW-1:0] m_ir  = '0;
    logic [DW-1:0] m_mdr = '0;
    logic          m_ea  = 1'b0;
    logic          m_et  = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk(tag, {bus.ir_out, bus.mdr_out, bus.err_align, bus.err_timeout},
            {m_ir, m_mdr, m_ea, m_et});
    endtask

    // One transaction, entered and left on a falling edge. ack_at is the ACCESS cycle
    // (1..T) in which memory acks, 0 for never. The request is presented in cycle 0;
    // the model says the memory is requested for n cycles, done appears in cycle n+1
    // and the port is idle again in cycle n+2, where the next request may be presented.
    task automatic run(input logic we, input logic irl, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int ack_at,
                       input logic [DW-1:0] rdata, input bit hold);
        bit mis;
        bit acked;
        int n;
        mis   = (addr[1:0] != 2'b00);
        acked = !mis && (ack_at >= 1) && (ack_at <= T);
        n     = mis ? 0 : (acked ? ack_at : T);

        bus.req_valid   = 1'b1;
        bus.req_we      = we;
        bus.req_ir_load = irl;
        bus.req_addr    = addr;
        bus.req_wdata   = wdata;

        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            if (c == 1 && !mis) begin
                m_ea = 1'b0;
                m_et = 1'b0;
            end
            if (c == n + 1) begin
                if (mis) begin
                    m_ea = 1'b1;
                    m_et = 1'b0;
                end else if (!acked) begin
                    m_et = 1'b1;
                end else if (!we) begin
                    if (irl) m_ir = rdata;
                    else     m_mdr = rdata;
                end
            end
            chk($sformatf("ctl c=%0d", c), {bus.busy, bus.done, bus.mem_req},
                {(c <= n + 1), (c == n + 1), (c <= n)});
            if (c <= n) begin
                chk($sformatf("bus c=%0d", c), {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                    {we, addr, wdata});
            end
            chk_regs($sformatf("regs c=%0d", c));

            bus.mem_ack   = (c == ack_at);
            bus.mem_rdata = (c == ack_at) ? rdata : DW'($urandom);
            if (!hold || c >= n + 1) bus.req_valid = 1'b0;
            if (hold) begin
                bus.req_addr  = AW'($urandom) & ~AW'(3);
                bus.req_wdata = DW'($urandom);
            end
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            k;

        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_ir_load = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;

        repeat (2) @(negedge clk);
        chk("reset ctl", {bus.busy, bus.done, bus.mem_req, bus.mem_we}, 4'b0000);
        chk("reset bus", {bus.mem_addr, bus.mem_wdata}, 64'h0);
        chk_regs("reset regs");
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle after reset", {bus.busy, bus.done, bus.mem_req}, 3'b000);

        // Read into IR, ack on the third ACCESS cycle.
        run(1'b0, 1'b1, 32'h0000_0040, 32'h1111_2222, 3, 32'h8C22_0004, 1'b0);
        // Write, ack on the first ACCESS cycle, immediately back-to-back.
        run(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h5555_AAAA, 1'b0);
        // Read into MDR.
        run(1'b0, 1'b0, 32'h0000_0200, 32'h0, 2, 32'h0BAD_F00D, 1'b0);
        // Misaligned read, then an aligned read that must clear err_align.
        run(1'b0, 1'b0, 32'h0000_0042, 32'h0, 0, 32'h0, 1'b0);
        run(1'b0, 1'b0, 32'h0000_0044, 32'h0, 2, 32'h1234_5678, 1'b0);
        // No ack: timeout after T request cycles.
        run(1'b0, 1'b1, 32'h0000_0080, 32'h0, 0, 32'h0, 1'b0);
        // Ack on the final count cycle beats the timeout.
        run(1'b0, 1'b1, 32'h0000_0084, 32'h0, T, 32'hCAFE_0001, 1'b0);
        // req_valid held through the access: only one acceptance.
        run(1'b0, 1'b0, 32'h0000_0088, 32'h0, 4, 32'h7777_0088, 1'b1);

        // Stray ack while idle produces nothing.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("stray ack 1", {bus.busy, bus.done, bus.mem_req}, 3'b000);
        chk_regs("stray ack regs");
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("stray ack 2", {bus.busy, bus.done, bus.mem_req}, 3'b000);

        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom) & ~AW'(3);
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d = DW'($urandom);
            k = int'($urandom_range(0, T));
            if ($urandom_range(0, 2) == 0) k = 1;
            run(1'($urandom), 1'($urandom), a, d, k, DW'($urandom), 1'($urandom));
        end

        // Reset pulsed between edges in the middle of an access.
        bus.req_valid   = 1'b1;
        bus.req_we      = 1'b0;
        bus.req_ir_load = 1'b1;
        bus.req_addr    = 32'h0000_0300;
        bus.req_wdata   = 32'h3030_3030;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset req", {bus.busy, bus.mem_req}, 2'b11);
        #1 reset_n = 1'b0;
        #1;
        m_ir  = '0;
        m_mdr = '0;
        m_ea  = 1'b0;
        m_et  = 1'b0;
        chk("async reset ctl", {bus.busy, bus.done, bus.mem_req, bus.mem_we}, 4'b0000);
        chk("async reset bus", {bus.mem_addr, bus.mem_wdata}, 64'h0);
        chk_regs("async reset regs");
        #1 reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post-reset idle c=%0d", c), {bus.busy, bus.done, bus.mem_req}, 3'b000);
        end
        run(1'b0, 1'b0, 32'h0000_0304, 32'h0, 1, 32'h4444_0304, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Multicycle memory-port sequencer placed directly downstream of the address and data 2:1 muxes (IorD address select, write-data select). It accepts one access request per instruction step from the control FSM and runs a req/ack handshake to a variable-latency memory. Read data is captured into the instruction register (IR) or the memory data register (MDR). Misaligned accesses and ack timeouts are flagged as exception-cause inputs for the cause logic.

## Interface
Parameters:
- ADDRESS_BUS_WIDTH, 32, address width; shared constant from parameters.v.
- DATA_BUS_WIDTH, 32, data width; shared constant from parameters.v.
- TIMEOUT_CYCLES, 16, maximum cycles mem_req is held without ack; must be ≥ 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request from control FSM, sampled only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_ir_load  in  1  read destination: 1 = IR, 0 = MDR.
- req_addr  in  ADDRESS_BUS_WIDTH  address from the IorD address mux.
- req_wdata  in  DATA_BUS_WIDTH  write data from the data mux.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err_align  out  1  misaligned-address flag.
- err_timeout  out  1  no-ack flag.
- ir_out  out  DATA_BUS_WIDTH  instruction register.
- mdr_out  out  DATA_BUS_WIDTH  memory data register.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDRESS_BUS_WIDTH  memory address.
- mem_wdata  out  DATA_BUS_WIDTH  memory write data.
- mem_ack  in  1  memory acknowledge; one cycle, qualified by mem_req.
- mem_rdata  in  DATA_BUS_WIDTH  read data, valid in the mem_ack cycle.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE with req_valid = 1 and req_addr[1:0] ≠ 0:
  - go to DONE; set err_align = 1 and err_timeout = 0.
  - no memory request is issued; IR and MDR are unchanged.
- IDLE with req_valid = 1 and aligned address:
  - latch addr, wdata, we, ir_load into the mem_* registers; clear both err flags.
  - clear the wait counter and go to ACCESS.
- ACCESS:
  - mem_req = 1; mem_addr, mem_we and mem_wdata are held stable.
  - On mem_ack with a read: load mem_rdata into IR (ir_load = 1) or MDR (ir_load = 0), then go to DONE.
  - On mem_ack with a write: go to DONE; IR and MDR are unchanged.
  - With no ack: if count == TIMEOUT_CYCLES−1, set err_timeout and go to DONE; otherwise count+1.
  - mem_ack on the final count cycle wins over the timeout.
- DONE: done = 1 for one cycle, then IDLE.
- req_valid outside IDLE is ignored; no queuing.
- mem_ack outside ACCESS is ignored.
- err_align and err_timeout are valid from the done cycle and hold until the next accepted request clears them.
- IR and MDR hold their value between loads.

## Timing
- Reset (asynchronous, active-low): state = IDLE; every output is 0, including ir_out, mdr_out, mem_addr and mem_wdata.
- Assertion of reset_n = 0 mid-ACCESS drops mem_req immediately; no done is generated.
- Request sampled at edge 0 → mem_req high from cycle 1.
- mem_ack sampled at edge k → IR/MDR updated and done high in cycle k+1; busy low in cycle k+2.
- Minimum latency, ack in the first ACCESS cycle: done 2 cycles after req_valid.
- Misaligned request: done and err_align high 1 cycle after req_valid; mem_req is never asserted.
- Timeout: mem_req high for exactly TIMEOUT_CYCLES cycles; done and err_timeout high in the following cycle.
- Back-to-back requests: the next request is accepted in the first IDLE cycle after done.
- All outputs are registered.

## Structure
- ADDRESS_BUS_WIDTH and DATA_BUS_WIDTH come from the shared parameters.v.
- FSM state encodings (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2) are added to parameters.v.
- One sub-module, mem_wait_counter: clear/enable inputs and a terminal-count output at TIMEOUT_CYCLES−1.
- IR, MDR and the FSM stay in mem_bus_ctrl.

## Test plan
- Reset mid-ACCESS, with reset_n pulsed low between edges → mem_req, done, busy, ir_out, mdr_out all 0 immediately; IDLE afterwards.
- Read, req_addr = 0x0000_0040, ir_load = 1, memory acks on 3rd ACCESS cycle with 0x8C22_0004 → ir_out = 0x8C22_0004 in the done cycle; mdr_out unchanged; done exactly 1 cycle wide.
- Write, addr = 0x0000_0100, wdata = 0xDEAD_BEEF, ack in 1st ACCESS cycle → mem_we = 1 and wdata stable while mem_req is high; done 2 cycles after request; IR and MDR unchanged.
- Read, req_addr = 0x0000_0042 → err_align = 1 with done 1 cycle later; mem_req never asserted; next aligned request clears err_align.
- No ack, TIMEOUT_CYCLES = 16 → mem_req high 16 cycles; done and err_timeout in cycle 17.
- Repeat with ack on the 16th ACCESS cycle → normal completion with err_timeout = 0.
- req_valid held high during ACCESS, plus a stray mem_ack in IDLE → exactly one access per IDLE acceptance; no spurious done.
